gt_tx_framer: RTL

//  Builds 8B/10B framed 32-bit words (data + charisk) for the GT channel TX user port (txusrclk2 domain).

---
 rtl/gt_frame_pkg.sv | 58 +++++
 rtl/gt_tx_framer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gt_frame_pkg.sv
// -----------------------------------------------------------------------------
// gt_frame_pkg
// Shared 8B/10B framing constants for the GT TX framer and the matching RX
// deframer. Contents:
//   - K-characters used for framing (K28.5 comma, K27.7 SOF, K29.7 EOF)
//   - IDLE / SOF code words with their charisk patterns
//   - EOF word builder and the abort count marker
//   - framer FSM state encoding
//   - popcount4 and byte-masking helpers
// -----------------------------------------------------------------------------
package gt_frame_pkg;

  localparam logic [7:0]  K28_5 = 8'hBC;
  localparam logic [7:0]  K27_7 = 8'hFB;
  localparam logic [7:0]  K29_7 = 8'hFD;

  // Comma idle: K28.5 in bytes 0 and 2, D16.2 (0x50) filler in bytes 1 and 3.
  localparam logic [31:0] IDLE_WORD = {8'h50, K28_5, 8'h50, K28_5};
  localparam logic [3:0]  IDLE_CHAR = 4'b0101;

  localparam logic [31:0] SOF_WORD  = {24'h50_5050, K27_7};
  localparam logic [3:0]  SOF_CHAR  = 4'b0001;

  localparam logic [3:0]  EOF_CHAR  = 4'b0001;
  localparam logic [7:0]  EOF_ABORT_CNT = 8'hFF;

  localparam logic [3:0]  DATA_CHAR = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_EOF,
    ST_DROP,
    ST_GAP
  } state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // EOF carries the byte count of the last payload word in byte 1.
  function automatic logic [31:0] eof_word(input logic [7:0] cnt);
    return {16'h0000, cnt, K29_7};
  endfunction

  // Bytes not flagged in tkeep are sent as zero so stale data never leaks.
  function automatic logic [31:0] mask_keep(input logic [31:0] data,
                                            input logic [3:0]  keep);
    logic [31:0] masked;
    masked = '0;
    for (int i = 0; i < 4; i++) begin
      masked[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/gt_tx_framer.sv
// -----------------------------------------------------------------------------
// gt_tx_framer
// Wraps 32-bit AXI-Stream packets as SOF / payload / EOF words for the GT TX
// user port (txusrclk2 domain). Gaps are filled with comma idles, a minimum
// idle gap follows every frame, and frames are aborted on oversize or TX
// link loss. Byte 0 (bits [7:0]) is transmitted first.
//
// Ports:
//   i_clk            TX user clock
//   i_rst            synchronous active-high reset
//   i_tx_done        GT TX reset-done; no new frame starts while low
//   i_s_axis_tdata   payload word
//   i_s_axis_tkeep   valid bytes, contiguous from LSB
//   i_s_axis_tlast   last beat of packet
//   i_s_axis_tvalid  upstream word valid
//   o_s_axis_tready  framer accepts a word this cycle (DATA / DROP only)
//   o_tx_data        word to GT txdata (registered)
//   o_tx_char        charisk to GT txcharisk (registered)
//   o_frame_cnt      frames completed with a good EOF, wraps
//   o_abort          one-cycle pulse aligned with the aborted frame's marker
// -----------------------------------------------------------------------------
module gt_tx_framer
  import gt_frame_pkg::*;
#(
  parameter int IDLE_MIN    = 2,
  parameter int MAX_PAYLOAD = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tx_done,
  input  logic [31:0] i_s_axis_tdata,
  input  logic [3:0]  i_s_axis_tkeep,
  input  logic        i_s_axis_tlast,
  input  logic        i_s_axis_tvalid,
  output logic        o_s_axis_tready,
  output logic [31:0] o_tx_data,
  output logic [3:0]  o_tx_char,
  output logic [15:0] o_frame_cnt,
  output logic        o_abort
);

  localparam int WCNT_W = $clog2(MAX_PAYLOAD + 1);
  localparam int GAP_W  = (IDLE_MIN > 1) ? $clog2(IDLE_MIN) : 1;

  state_e              state_q;
  logic [WCNT_W-1:0]   word_cnt_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [7:0]          eof_cnt_q;
  logic [31:0]         tx_data_q;
  logic [3:0]          tx_char_q;
  logic [15:0]         frame_cnt_q;
  logic                abort_q;

  logic                xfer;

  assign o_s_axis_tready = (state_q == ST_DATA) || (state_q == ST_DROP);
  assign xfer            = i_s_axis_tvalid && o_s_axis_tready;

  assign o_tx_data   = tx_data_q;
  assign o_tx_char   = tx_char_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_abort     = abort_q;

  // Each state decides the word that goes out on the following cycle, so the
  // word emitted by state X appears on o_tx_data while the FSM is in X's
  // successor.
  // NOTE: every assignment in this clocked block is non-blocking so all
  // registers update together from the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      eof_cnt_q   <= '0;
      tx_data_q   <= IDLE_WORD;
      tx_char_q   <= IDLE_CHAR;
      frame_cnt_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      // Comma fill unless a state below claims the output slot.
      tx_data_q <= IDLE_WORD;
      tx_char_q <= IDLE_CHAR;
      abort_q   <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (i_tx_done && i_s_axis_tvalid) state_q <= ST_SOF;
        end

        ST_SOF: begin
          word_cnt_q <= '0;
          if (!i_tx_done) begin
            abort_q <= 1'b1;
            state_q <= ST_DROP;
          end else begin
            tx_data_q <= SOF_WORD;
            tx_char_q <= SOF_CHAR;
            state_q   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (!i_tx_done) begin
            // Link lost: no EOF; the beat taken this cycle (if any) is dropped.
            abort_q   <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= (xfer && i_s_axis_tlast) ? ST_GAP : ST_DROP;
          end else if (xfer) begin
            if (word_cnt_q == WCNT_W'(MAX_PAYLOAD)) begin
              // Oversize beat replaced by the abort EOF; beats the rest away.
              tx_data_q <= eof_word(EOF_ABORT_CNT);
              tx_char_q <= EOF_CHAR;
              abort_q   <= 1'b1;
              gap_cnt_q <= '0;
              state_q   <= i_s_axis_tlast ? ST_GAP : ST_DROP;
            end else begin
              tx_data_q  <= mask_keep(i_s_axis_tdata, i_s_axis_tkeep);
              tx_char_q  <= DATA_CHAR;
              word_cnt_q <= word_cnt_q + 1'b1;
              if (i_s_axis_tlast) begin
                eof_cnt_q <= {5'b00000, popcount4(i_s_axis_tkeep)};
                state_q   <= ST_EOF;
              end
            end
          end
        end

        ST_EOF: begin
          gap_cnt_q <= '0;
          state_q   <= ST_GAP;
          if (!i_tx_done) begin
            // The packet's tlast is already consumed, so nothing is left to
            // drain: skip DROP and go straight to the gap.
            abort_q <= 1'b1;
          end else begin
            tx_data_q   <= eof_word(eof_cnt_q);
            tx_char_q   <= EOF_CHAR;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end

        ST_DROP: begin
          if (xfer && i_s_axis_tlast) begin
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end
        end

        ST_GAP: begin
          // The last gap cycle may launch SOF directly so that exactly
          // IDLE_MIN idles separate back-to-back frames.
          if (gap_cnt_q == GAP_W'(IDLE_MIN - 1)) begin
            state_q <= (i_tx_done && i_s_axis_tvalid) ? ST_SOF : ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
